control_fsm: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Fetches one instruction opcode per instruction through a ready/valid handshake and sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives datapath control strobes and supports multi-cycle MUL, memory wait states, branch/jump/IRET PC selection, TLB write and an illegal-opcode trap.
- Sits between the instruction/data memory interfaces and the register file, ALU and PC logic of the CPU.

---
 rtl/control_fsm_pkg.sv | 66 ++++++
 rtl/control_fsm_if.sv | 45 ++++
 rtl/control_decode.sv | 83 ++++++++
 rtl/control_fsm.sv | 176 +++++++++++++++++
 tb/tb_control_fsm.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/control_fsm_pkg.sv
// control_fsm shared types: opcodes, ALU codes, PC sources,
// state and instruction-class encodings, strobe bundle.
package control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_MUL, C_LOAD, C_STORE, C_BRANCH,
    C_JUMP, C_TLB, C_IRET, C_ILLEGAL
  } cls_e;

  localparam logic [31:0] OP_ADD  = 32'd0;
  localparam logic [31:0] OP_SUB  = 32'd1;
  localparam logic [31:0] OP_MUL  = 32'd2;
  localparam logic [31:0] OP_AND  = 32'd3;
  localparam logic [31:0] OP_OR   = 32'd4;
  localparam logic [31:0] OP_ADDI = 32'd5;
  localparam logic [31:0] OP_LDB  = 32'd10;
  localparam logic [31:0] OP_LDW  = 32'd11;
  localparam logic [31:0] OP_STB  = 32'd12;
  localparam logic [31:0] OP_STW  = 32'd13;
  localparam logic [31:0] OP_MOV  = 32'd14;
  localparam logic [31:0] OP_BEQ  = 32'd20;
  localparam logic [31:0] OP_JUMP = 32'd21;
  localparam logic [31:0] OP_TLBW = 32'd30;
  localparam logic [31:0] OP_IRET = 32'd31;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_MUL  = 2;
  localparam int ALU_AND  = 3;
  localparam int ALU_OR   = 4;
  localparam int ALU_PASS = 5;

  localparam logic [2:0] PC_INC    = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_EPC    = 3'd3;
  localparam logic [2:0] PC_TRAP   = 3'd4;

  typedef struct packed {
    logic       if_req;
    logic       pc_write;
    logic [2:0] pc_src;
    logic       reg_dest;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
    logic       mem_to_reg;
    logic       reg_write;
    logic       tlb_write;
    logic       iret;
    logic       illegal_op;
    logic       retire;
  } ctl_t;

endpackage

// File: rtl/control_fsm_if.sv
// control_fsm bus: fetch handshake, data memory handshake
// and datapath control strobes.
interface control_fsm_if #(
  parameter int OP_W  = 6,
  parameter int ALU_W = 4
);
  logic [OP_W-1:0]  op;
  logic             if_ready;
  logic             mem_ready;
  logic             zero;
  logic             if_req;
  logic             pc_write;
  logic [2:0]       pc_src;
  logic             reg_dest;
  logic             alu_src;
  logic [ALU_W-1:0] alu_ctrl;
  logic             mem_read;
  logic             mem_write;
  logic             mem_byte;
  logic             mem_to_reg;
  logic             reg_write;
  logic             tlb_write;
  logic             iret;
  logic             illegal_op;
  logic             retire;
  logic [2:0]       state_o;

  modport master (
    input  op, if_ready, mem_ready, zero,
    output if_req, pc_write, pc_src, reg_dest,
    output alu_src, alu_ctrl, mem_read, mem_write,
    output mem_byte, mem_to_reg, reg_write,
    output tlb_write, iret, illegal_op, retire,
    output state_o
  );

  modport slave (
    output op, if_ready, mem_ready, zero,
    input  if_req, pc_write, pc_src, reg_dest,
    input  alu_src, alu_ctrl, mem_read, mem_write,
    input  mem_byte, mem_to_reg, reg_write,
    input  tlb_write, iret, illegal_op, retire,
    input  state_o
  );
endinterface

// File: rtl/control_decode.sv
// control_decode: opcode -> instruction class and the
// datapath fields that stay stable from DECODE to WB.
module control_decode
  import control_fsm_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int ALU_W = 4
) (
  input  logic [OP_W-1:0]  i_op,
  output cls_e             o_cls,
  output logic             o_reg_dest,
  output logic             o_alu_src,
  output logic [ALU_W-1:0] o_alu_ctrl,
  output logic             o_mem_byte,
  output logic             o_illegal
);
  logic [31:0] w_op;
  assign w_op = 32'(i_op);

  // classify opcode; anything not in the table is illegal
  always_comb begin
    o_cls      = C_ALU;
    o_reg_dest = 1'b0;
    o_alu_src  = 1'b0;
    o_alu_ctrl = '0;
    o_mem_byte = 1'b0;
    o_illegal  = 1'b0;
    unique case (1'b1)
      (w_op == OP_ADD): begin
        o_reg_dest = 1'b1;
        o_alu_ctrl = ALU_W'(ALU_ADD);
      end
      (w_op == OP_SUB): begin
        o_reg_dest = 1'b1;
        o_alu_ctrl = ALU_W'(ALU_SUB);
      end
      (w_op == OP_MUL): begin
        o_cls      = C_MUL;
        o_reg_dest = 1'b1;
        o_alu_ctrl = ALU_W'(ALU_MUL);
      end
      (w_op == OP_AND): begin
        o_reg_dest = 1'b1;
        o_alu_ctrl = ALU_W'(ALU_AND);
      end
      (w_op == OP_OR): begin
        o_reg_dest = 1'b1;
        o_alu_ctrl = ALU_W'(ALU_OR);
      end
      (w_op == OP_ADDI): begin
        o_alu_src  = 1'b1;
        o_alu_ctrl = ALU_W'(ALU_ADD);
      end
      (w_op == OP_MOV): begin
        o_reg_dest = 1'b1;
        o_alu_ctrl = ALU_W'(ALU_PASS);
      end
      (w_op == OP_LDB), (w_op == OP_LDW): begin
        o_cls      = C_LOAD;
        o_alu_src  = 1'b1;
        o_alu_ctrl = ALU_W'(ALU_ADD);
        o_mem_byte = (w_op == OP_LDB);
      end
      (w_op == OP_STB), (w_op == OP_STW): begin
        o_cls      = C_STORE;
        o_alu_src  = 1'b1;
        o_alu_ctrl = ALU_W'(ALU_ADD);
        o_mem_byte = (w_op == OP_STB);
      end
      (w_op == OP_BEQ): begin
        o_cls      = C_BRANCH;
        o_alu_ctrl = ALU_W'(ALU_SUB);
      end
      (w_op == OP_JUMP): o_cls = C_JUMP;
      (w_op == OP_TLBW): o_cls = C_TLB;
      (w_op == OP_IRET): o_cls = C_IRET;
      default: begin
        o_cls     = C_ILLEGAL;
        o_illegal = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
// with MUL stall, memory wait states and illegal-op trap.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int ALU_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int TRAP_EN    = 1
) (
  input logic           clk,
  input logic           rst_n,
  control_fsm_if.master bus
);
  localparam int CNT_W = 4;

  state_e           r_state, w_ns;
  logic [OP_W-1:0]  r_op_q, w_op_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  cls_e             r_cls, w_cls;
  ctl_t             r_ctl, w_ctl;
  logic [ALU_W-1:0] r_alu, w_alu, w_dalu;
  logic             w_rd, w_as, w_mb, w_ill;
  logic             w_fetch_hs, w_beq_take, w_st_done;

  // decode the opcode that will be held next cycle
  control_decode #(.OP_W(OP_W), .ALU_W(ALU_W)) u_dec (
    .i_op       (w_op_n),
    .o_cls      (w_cls),
    .o_reg_dest (w_rd),
    .o_alu_src  (w_as),
    .o_alu_ctrl (w_dalu),
    .o_mem_byte (w_mb),
    .o_illegal  (w_ill)
  );

  assign w_fetch_hs = (r_state == S_FETCH) && bus.if_ready;
  assign w_beq_take = (r_state == S_EXEC) &&
                      (r_cls == C_BRANCH) && bus.zero;
  assign w_st_done  = (r_state == S_MEM) &&
                      (r_cls == C_STORE) && bus.mem_ready;

  // next state, opcode latch and MUL countdown
  always_comb begin
    w_ns    = r_state;
    w_op_n  = r_op_q;
    w_cnt_n = r_cnt;
    case (r_state)
      S_IDLE: w_ns = S_FETCH;
      S_FETCH: begin
        if (w_fetch_hs) begin
          w_op_n = bus.op;
          w_ns   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_ill) begin
          w_ns = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
        end else begin
          w_ns    = S_EXEC;
          w_cnt_n = CNT_W'(MUL_CYCLES - 1);
        end
      end
      S_EXEC: begin
        case (w_cls)
          C_MUL:
            if (r_cnt == '0) w_ns = S_WB;
            else w_cnt_n = r_cnt - CNT_W'(1);
          C_ALU:           w_ns = S_WB;
          C_LOAD, C_STORE: w_ns = S_MEM;
          default:         w_ns = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)
          w_ns = (w_cls == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB:    w_ns = S_FETCH;
      S_TRAP:  w_ns = S_FETCH;
      default: w_ns = S_FETCH;
    endcase
  end

  // strobes for the state being entered, registered below
  always_comb begin
    w_ctl        = '0;
    w_ctl.pc_src = PC_INC;
    w_alu        = '0;
    if (w_ns inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      w_ctl.reg_dest = w_rd;
      w_ctl.alu_src  = w_as;
      w_alu          = w_dalu;
    end
    case (w_ns)
      S_FETCH:  w_ctl.if_req = 1'b1;
      S_DECODE: w_ctl.retire = w_ill && (TRAP_EN == 0);
      S_EXEC: begin
        case (w_cls)
          C_BRANCH: begin
            w_ctl.pc_src = PC_BRANCH;
            w_ctl.retire = 1'b1;
          end
          C_JUMP: begin
            w_ctl.pc_write = 1'b1;
            w_ctl.pc_src   = PC_JUMP;
            w_ctl.retire   = 1'b1;
          end
          C_TLB: begin
            w_ctl.tlb_write = 1'b1;
            w_ctl.retire    = 1'b1;
          end
          C_IRET: begin
            w_ctl.iret     = 1'b1;
            w_ctl.pc_write = 1'b1;
            w_ctl.pc_src   = PC_EPC;
            w_ctl.retire   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_ctl.mem_read  = (w_cls == C_LOAD);
        w_ctl.mem_write = (w_cls == C_STORE);
        w_ctl.mem_byte  = w_mb;
      end
      S_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = (w_cls == C_LOAD);
        w_ctl.retire     = 1'b1;
      end
      S_TRAP: begin
        w_ctl.illegal_op = 1'b1;
        w_ctl.pc_write   = 1'b1;
        w_ctl.pc_src     = PC_TRAP;
        w_ctl.retire     = 1'b1;
      end
      default: ;
    endcase
  end

  // state, opcode, MUL counter and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_q  <= '0;
      r_cnt   <= '0;
      r_cls   <= C_ALU;
      r_ctl   <= '0;
      r_alu   <= '0;
    end else begin
      r_state <= w_ns;
      r_op_q  <= w_op_n;
      r_cnt   <= w_cnt_n;
      r_cls   <= w_cls;
      r_ctl   <= w_ctl;
      r_alu   <= w_alu;
    end
  end

  assign bus.if_req     = r_ctl.if_req;
  assign bus.pc_write   = r_ctl.pc_write | w_fetch_hs | w_beq_take;
  assign bus.pc_src     = r_ctl.pc_src;
  assign bus.reg_dest   = r_ctl.reg_dest;
  assign bus.alu_src    = r_ctl.alu_src;
  assign bus.alu_ctrl   = r_alu;
  assign bus.mem_read   = r_ctl.mem_read;
  assign bus.mem_write  = r_ctl.mem_write;
  assign bus.mem_byte   = r_ctl.mem_byte;
  assign bus.mem_to_reg = r_ctl.mem_to_reg;
  assign bus.reg_write  = r_ctl.reg_write;
  assign bus.tlb_write  = r_ctl.tlb_write;
  assign bus.iret       = r_ctl.iret;
  assign bus.illegal_op = r_ctl.illegal_op;
  assign bus.retire     = r_ctl.retire | w_st_done;
  assign bus.state_o    = r_state;
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed vector table plus hand sequences
// for async reset, MUL_CYCLES=1 and TRAP_EN=0.
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  control_fsm_if #(.OP_W(6), .ALU_W(4)) if_a ();
  control_fsm_if #(.OP_W(6), .ALU_W(4)) if_b ();

  control_fsm #(
    .OP_W(6), .ALU_W(4), .MUL_CYCLES(4), .TRAP_EN(1)
  ) u_a (.clk(clk), .rst_n(rst_a), .bus(if_a));

  control_fsm #(
    .OP_W(6), .ALU_W(4), .MUL_CYCLES(1), .TRAP_EN(0)
  ) u_b (.clk(clk), .rst_n(rst_b), .bus(if_b));

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  pcs;
    logic [3:0]  alu;
    logic [12:0] f;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       ifr;
    logic [5:0] op;
    logic       mr;
    logic       z;
    out_t       x;
  } vec_t;

  localparam logic [12:0] IFQ = 13'h1000;
  localparam logic [12:0] PCW = 13'h0800;
  localparam logic [12:0] RD  = 13'h0400;
  localparam logic [12:0] AS  = 13'h0200;
  localparam logic [12:0] MR  = 13'h0100;
  localparam logic [12:0] MW  = 13'h0080;
  localparam logic [12:0] MB  = 13'h0040;
  localparam logic [12:0] M2R = 13'h0020;
  localparam logic [12:0] RW  = 13'h0010;
  localparam logic [12:0] TLB = 13'h0008;
  localparam logic [12:0] IRT = 13'h0004;
  localparam logic [12:0] ILL = 13'h0002;
  localparam logic [12:0] RET = 13'h0001;

  out_t act_a, act_b;
  always_comb act_a = {if_a.state_o, if_a.pc_src, if_a.alu_ctrl,
    if_a.if_req, if_a.pc_write, if_a.reg_dest, if_a.alu_src,
    if_a.mem_read, if_a.mem_write, if_a.mem_byte, if_a.mem_to_reg,
    if_a.reg_write, if_a.tlb_write, if_a.iret, if_a.illegal_op,
    if_a.retire};
  always_comb act_b = {if_b.state_o, if_b.pc_src, if_b.alu_ctrl,
    if_b.if_req, if_b.pc_write, if_b.reg_dest, if_b.alu_src,
    if_b.mem_read, if_b.mem_write, if_b.mem_byte, if_b.mem_to_reg,
    if_b.reg_write, if_b.tlb_write, if_b.iret, if_b.illegal_op,
    if_b.retire};

  int n_cmp = 0;
  int n_bad = 0;
  vec_t  tv[$];
  string tn[$];

  function automatic out_t e(input logic [2:0] st,
      input logic [2:0] pcs, input logic [3:0] alu,
      input logic [12:0] f);
    return {st, pcs, alu, f};
  endfunction

  task automatic v(input string nm, input logic rst,
      input logic ifr, input logic [5:0] op, input logic mr,
      input logic z, input logic [2:0] st, input logic [2:0] pcs,
      input logic [3:0] alu, input logic [12:0] f);
    tv.push_back({rst, ifr, op, mr, z, e(st, pcs, alu, f)});
    tn.push_back(nm);
  endtask

  task automatic chk(input string nm, input out_t a, input out_t x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got st=%0d pcs=%0d alu=%0d fl=%b, want st=%0d pcs=%0d alu=%0d fl=%b",
        nm, a.st, a.pcs, a.alu, a.f, x.st, x.pcs, x.alu, x.f);
    end
  endtask

  // one clock: drive at negedge, compare 1ns later
  task automatic step(input bit sel_b, input string nm,
      input logic rst, input logic ifr, input logic [5:0] op,
      input logic mr, input logic z, input out_t x);
    @(negedge clk);
    if (sel_b) rst_b = rst;
    else rst_a = rst;
    if_a.if_ready = ifr;  if_b.if_ready = ifr;
    if_a.op = op;         if_b.op = op;
    if_a.mem_ready = mr;  if_b.mem_ready = mr;
    if_a.zero = z;        if_b.zero = z;
    #1;
    chk(nm, sel_b ? act_b : act_a, x);
  endtask

  initial begin
    if_a.if_ready = 1'b0; if_b.if_ready = 1'b0;
    if_a.op = '0;         if_b.op = '0;
    if_a.mem_ready = 1'b0; if_b.mem_ready = 1'b0;
    if_a.zero = 1'b0;     if_b.zero = 1'b0;

    v("rst",      0,1, 0,1,1, S_IDLE,  0,0, 0);
    v("idle",     1,0, 0,0,0, S_IDLE,  0,0, 0);
    v("add_f",    1,1, 0,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("add_d",    1,1,63,0,0, S_DECODE,0,0, RD);
    v("add_e",    1,0,63,1,1, S_EXEC,  0,0, RD);
    v("add_w",    1,0,63,1,0, S_WB,    0,0, RD|RW|RET);
    v("mul_stall",1,0, 2,0,0, S_FETCH, 0,0, IFQ);
    v("mul_f",    1,1, 2,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("mul_d",    1,0, 0,0,0, S_DECODE,0,2, RD);
    v("mul_e1",   1,0, 0,0,0, S_EXEC,  0,2, RD);
    v("mul_e2",   1,1, 0,0,0, S_EXEC,  0,2, RD);
    v("mul_e3",   1,0, 0,0,0, S_EXEC,  0,2, RD);
    v("mul_e4",   1,0, 0,0,0, S_EXEC,  0,2, RD);
    v("mul_w",    1,0, 0,0,0, S_WB,    0,2, RD|RW|RET);
    v("ldb_f",    1,1,10,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("ldb_d",    1,0,10,1,0, S_DECODE,0,0, AS);
    v("ldb_e",    1,0,10,1,0, S_EXEC,  0,0, AS);
    v("ldb_m1",   1,0,10,0,0, S_MEM,   0,0, AS|MR|MB);
    v("ldb_m2",   1,0,10,0,0, S_MEM,   0,0, AS|MR|MB);
    v("ldb_m3",   1,0,10,0,0, S_MEM,   0,0, AS|MR|MB);
    v("ldb_m4",   1,0,10,1,0, S_MEM,   0,0, AS|MR|MB);
    v("ldb_w",    1,0,10,0,0, S_WB,    0,0, AS|M2R|RW|RET);
    v("stw_f",    1,1,13,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("stw_d",    1,0,13,0,0, S_DECODE,0,0, AS);
    v("stw_e",    1,0,13,0,0, S_EXEC,  0,0, AS);
    v("stw_m1",   1,0,13,0,0, S_MEM,   0,0, AS|MW);
    v("stw_m2",   1,0,13,1,0, S_MEM,   0,0, AS|MW|RET);
    v("beq1_f",   1,1,20,0,1, S_FETCH, 0,0, IFQ|PCW);
    v("beq1_d",   1,0,20,0,1, S_DECODE,0,1, 0);
    v("beq1_e",   1,0,20,0,1, S_EXEC,  1,1, PCW|RET);
    v("beq0_f",   1,1,20,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("beq0_d",   1,0,20,0,1, S_DECODE,0,1, 0);
    v("beq0_e",   1,0,20,0,0, S_EXEC,  1,1, RET);
    v("iret_f",   1,1,31,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("iret_d",   1,0,31,0,0, S_DECODE,0,0, 0);
    v("iret_e",   1,0,31,0,0, S_EXEC,  3,0, IRT|PCW|RET);
    v("ill7_f",   1,1, 7,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("ill7_d",   1,0, 7,0,0, S_DECODE,0,0, 0);
    v("ill7_t",   1,0, 7,0,0, S_TRAP,  4,0, ILL|PCW|RET);
    v("jmp_f",    1,1,21,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("jmp_d",    1,0,21,0,0, S_DECODE,0,0, 0);
    v("jmp_e",    1,0,21,0,0, S_EXEC,  2,0, PCW|RET);
    v("tlb_f",    1,1,30,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("tlb_d",    1,0,30,0,0, S_DECODE,0,0, 0);
    v("tlb_e",    1,0,30,0,0, S_EXEC,  0,0, TLB|RET);
    v("mov_f",    1,1,14,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("mov_d",    1,0,14,0,0, S_DECODE,0,5, RD);
    v("mov_e",    1,0,14,0,0, S_EXEC,  0,5, RD);
    v("mov_w",    1,0,14,0,0, S_WB,    0,5, RD|RW|RET);
    v("ill40_f",  1,1,40,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("ill40_d",  1,0,40,0,0, S_DECODE,0,0, 0);
    v("ill40_t",  1,0,40,0,0, S_TRAP,  4,0, ILL|PCW|RET);
    v("addi_f",   1,1, 5,0,0, S_FETCH, 0,0, IFQ|PCW);
    v("addi_d",   1,0, 5,0,0, S_DECODE,0,0, AS);
    v("addi_e",   1,0, 5,0,0, S_EXEC,  0,0, AS);
    v("addi_w",   1,0, 5,0,0, S_WB,    0,0, AS|RW|RET);
    v("fetch_hold",1,0,0,0,0, S_FETCH, 0,0, IFQ);

    for (int i = 0; i < tv.size(); i++)
      step(0, tn[i], tv[i].rst, tv[i].ifr, tv[i].op,
           tv[i].mr, tv[i].z, tv[i].x);

    step(0, "ldw_f", 1,1,11,0,0, e(S_FETCH, 0,0, IFQ|PCW));
    step(0, "ldw_d", 1,0,11,0,0, e(S_DECODE,0,0, AS));
    step(0, "ldw_e", 1,0,11,0,0, e(S_EXEC,  0,0, AS));
    step(0, "ldw_m", 1,0,11,0,0, e(S_MEM,   0,0, AS|MR));
    #2 rst_a = 1'b0;
    #1 chk("async_rst", act_a, '0);
    step(0, "rst_hold", 0,1,11,1,0, '0);
    step(0, "rst_rel",  1,0,11,0,0, e(S_IDLE, 0,0, 0));
    step(0, "post_f",   1,0,11,0,0, e(S_FETCH,0,0, IFQ));

    step(1, "b_rst",   0,0, 0,0,0, '0);
    step(1, "b_idle",  1,0, 0,0,0, e(S_IDLE,  0,0, 0));
    step(1, "b_mul_f", 1,1, 2,0,0, e(S_FETCH, 0,0, IFQ|PCW));
    step(1, "b_mul_d", 1,0, 2,0,0, e(S_DECODE,0,2, RD));
    step(1, "b_mul_e", 1,0, 2,0,0, e(S_EXEC,  0,2, RD));
    step(1, "b_mul_w", 1,0, 2,0,0, e(S_WB,    0,2, RD|RW|RET));
    step(1, "b_ill_f", 1,1, 7,0,0, e(S_FETCH, 0,0, IFQ|PCW));
    step(1, "b_ill_d", 1,0, 7,0,0, e(S_DECODE,0,0, RET));
    step(1, "b_ill_x", 1,0, 7,0,0, e(S_FETCH, 0,0, IFQ));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
